// File: rtl/lcd_pkg.sv
// lcd_pkg: shared definitions for the LCD writer and init sequencer.
//   - FSM state constants for lcd_writer
//   - HD44780 command byte constants
//   - default timing constants in clk cycles at 50 MHz
//   - configuration ROM lookup and long-command classification
package lcd_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_PULSE = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;
    localparam logic [2:0] ST_READY = 3'd5;

    localparam logic [7:0] CMD_FUNC_SET = 8'h38;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_HOME     = 8'h02;
    localparam logic [7:0] CMD_LINE1    = 8'h80;
    localparam logic [7:0] CMD_LINE2    = 8'hC0;

    localparam int unsigned DEF_E_CYCLES   = 12;
    localparam int unsigned DEF_WAIT_CMD   = 2000;
    localparam int unsigned DEF_WAIT_CLEAR = 82000;

    // Wide enough for the longest wait (82000) without wrapping.
    localparam int unsigned TIMER_W = 17;

    function automatic logic [7:0] cfg_rom(input logic [1:0] idx);
        case (idx)
            2'd0:    return CMD_FUNC_SET;
            2'd1:    return CMD_ENTRY;
            2'd2:    return CMD_DISP_ON;
            default: return CMD_CLEAR;
        endcase
    endfunction

    // Clear and home need the long execution wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] b);
        return !rs && ((b == CMD_CLEAR) || (b == CMD_HOME));
    endfunction

endpackage

// File: rtl/lcd_timer.sv
// lcd_timer: loadable down-counter with zero flag.
//   clk, reset  : clock, synchronous active-high reset
//   load        : load load_val this cycle
//   load_val    : count to load
//   zero        : count has reached zero (holds at zero)
module lcd_timer
    import lcd_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    output logic               zero
);

    logic [TIMER_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/lcd_writer.sv
// lcd_writer: sends the HD44780 configuration bytes after init_done, then
// forwards application bytes over a valid/ready handshake, generating
// lcd_rs/lcd_e/lcd_db with setup, enable pulse and execution wait.
// Bus outputs are zero when idle so they can be ORed with the init sequencer.
//   clk, reset          : clock, synchronous active-high reset
//   init_done           : one-cycle start pulse from init sequencer
//   wr_valid/wr_ready   : application byte handshake
//   wr_rs, wr_data      : register select and byte to write
//   cfg_done            : configuration finished (sticky until reset)
//   lcd_db/lcd_rs/lcd_rw/lcd_e : LCD bus (lcd_rw tied 0)
// Optional: define LCD_AUTO_WRAP_EN to insert line-change commands at
// columns 16 and 32 of a 2x16 display.
module lcd_writer
    import lcd_pkg::*;
#(
    parameter int unsigned E_CYCLES   = DEF_E_CYCLES,
    parameter int unsigned WAIT_CMD   = DEF_WAIT_CMD,
    parameter int unsigned WAIT_CLEAR = DEF_WAIT_CLEAR
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       init_done,
    input  logic       wr_valid,
    input  logic       wr_rs,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    output logic       cfg_done,
    output logic [7:0] lcd_db,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e
);

    // Timer loads count-1 so a state lasting N cycles exits on the Nth.
    localparam logic [TIMER_W-1:0] LD_PULSE = TIMER_W'(E_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LD_CMD   = TIMER_W'(WAIT_CMD - 1);
    localparam logic [TIMER_W-1:0] LD_CLEAR = TIMER_W'(WAIT_CLEAR - 1);

    logic [2:0]         state, state_nx;
    logic               cur_rs;
    logic [7:0]         cur_data;
    logic [1:0]         cfg_idx;
    logic               cfg_done_r;
    logic               more_cfg;
    logic               pend_valid;
    logic               tmr_load, tmr_zero;
    logic [TIMER_W-1:0] tmr_val;
    logic               bus_on;

`ifdef LCD_AUTO_WRAP_EN
    logic [7:0] pend_data;
    logic [4:0] col;
    logic       wrapped;   // column counter passed 31; next char needs line 1
`else
    assign pend_valid = 1'b0;
`endif

    lcd_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    assign more_cfg = !cfg_done_r && (cfg_idx != 2'd3);

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (init_done) state_nx = ST_SETUP;
            ST_SETUP: if (tmr_zero)  state_nx = ST_PULSE;
            ST_PULSE: if (tmr_zero)  state_nx = ST_HOLD;
            ST_HOLD:  if (tmr_zero)  state_nx = ST_WAIT;
            ST_WAIT:  if (tmr_zero)  state_nx = (more_cfg || pend_valid) ? ST_SETUP : ST_READY;
            ST_READY: if (wr_valid)  state_nx = ST_SETUP;
            default:                 state_nx = ST_IDLE;
        endcase
    end

    // Every transition is a state entry, so the timer reloads on any change.
    always_comb begin
        tmr_load = (state_nx != state);
        tmr_val  = '0;
        case (state_nx)
            ST_PULSE: tmr_val = LD_PULSE;
            ST_WAIT:  tmr_val = is_long_cmd(cur_rs, cur_data) ? LD_CLEAR : LD_CMD;
            default:  tmr_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cur_rs     <= 1'b0;
            cur_data   <= '0;
            cfg_idx    <= '0;
            cfg_done_r <= 1'b0;
`ifdef LCD_AUTO_WRAP_EN
            pend_valid <= 1'b0;
            pend_data  <= '0;
            col        <= '0;
            wrapped    <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            case (state)
                ST_IDLE: begin
                    if (init_done) begin
                        cur_rs   <= 1'b0;
                        cur_data <= cfg_rom(2'd0);
                        cfg_idx  <= 2'd0;
                    end
                end
                ST_WAIT: begin
                    if (tmr_zero) begin
                        if (more_cfg) begin
                            cfg_idx  <= cfg_idx + 2'd1;
                            cur_data <= cfg_rom(cfg_idx + 2'd1);
`ifdef LCD_AUTO_WRAP_EN
                        end else if (pend_valid) begin
                            cur_rs     <= 1'b1;
                            cur_data   <= pend_data;
                            pend_valid <= 1'b0;
`endif
                        end else begin
                            cfg_done_r <= 1'b1;
                        end
                    end
                end
                ST_READY: begin
                    if (wr_valid) begin
`ifdef LCD_AUTO_WRAP_EN
                        // A line-change command goes out first; the character
                        // waits in pend_data until that transaction finishes.
                        if (wr_rs && (col == 5'd16)) begin
                            cur_rs     <= 1'b0;
                            cur_data   <= CMD_LINE2;
                            pend_valid <= 1'b1;
                            pend_data  <= wr_data;
                        end else if (wr_rs && (col == 5'd0) && wrapped) begin
                            cur_rs     <= 1'b0;
                            cur_data   <= CMD_LINE1;
                            pend_valid <= 1'b1;
                            pend_data  <= wr_data;
                            wrapped    <= 1'b0;
                        end else begin
                            cur_rs   <= wr_rs;
                            cur_data <= wr_data;
                        end
                        if (wr_rs) begin
                            col <= col + 5'd1;
                            if (col == 5'd31) wrapped <= 1'b1;
                        end else if (is_long_cmd(1'b0, wr_data)) begin
                            col     <= '0;
                            wrapped <= 1'b0;
                        end else if (wr_data[7]) begin
                            col     <= {wr_data[6], wr_data[3:0]};
                            wrapped <= 1'b0;
                        end
`else
                        cur_rs   <= wr_rs;
                        cur_data <= wr_data;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus_on   = (state == ST_SETUP) || (state == ST_PULSE) ||
                      (state == ST_HOLD)  || (state == ST_WAIT);
    assign lcd_db   = bus_on ? cur_data : '0;
    assign lcd_rs   = bus_on & cur_rs;
    assign lcd_e    = (state == ST_PULSE);
    assign lcd_rw   = 1'b0;
    assign wr_ready = (state == ST_READY);
    assign cfg_done = cfg_done_r;

endmodule

// File: tb/tb_lcd_writer.sv
// Scoreboard bench for lcd_writer with shortened timing parameters.
module tb_lcd_writer;

    localparam int E   = 4;
    localparam int WC  = 20;
    localparam int WCL = 100;
    localparam int N_COST    = 2 + E + WC;
    localparam int C_COST    = 2 + E + WCL;
    localparam int INIT_COST = 3 * N_COST + C_COST;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       init_done = 1'b0;
    logic       wr_valid = 1'b0;
    logic       wr_rs = 1'b0;
    logic [7:0] wr_data = '0;
    logic       wr_ready, cfg_done, lcd_rs, lcd_rw, lcd_e;
    logic [7:0] lcd_db;

    lcd_writer #(
        .E_CYCLES   (E),
        .WAIT_CMD   (WC),
        .WAIT_CLEAR (WCL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .init_done (init_done),
        .wr_valid  (wr_valid),
        .wr_rs     (wr_rs),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .cfg_done  (cfg_done),
        .lcd_db    (lcd_db),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_e     (lcd_e)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rs;
        logic [7:0] db;
        int         w;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic expect_tx(input logic rs, input logic [7:0] db, input int w);
        exp_t e;
        e.rs = rs;
        e.db = db;
        e.w  = w;
        exp_q.push_back(e);
    endtask

    // Monitor: samples on negedge, pops one expectation per lcd_e pulse.
    int         phase = 0;
    int         mcnt = 0;
    logic [8:0] prev_bus = '0;
    logic [8:0] held = '0;
    int         cur_w = 0;

    always @(negedge clk) begin
        logic [8:0] bus;
        exp_t e;
        bus = {lcd_rs, lcd_db};
        if (reset) begin
            phase = 0;
        end else begin
            case (phase)
                0: if (lcd_e) begin
                    check("tx_expected", int'(exp_q.size() > 0), 1);
                    check("setup_bus", int'(prev_bus), int'(bus));
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("tx_rs", int'(lcd_rs), int'(e.rs));
                        check("tx_db", int'(lcd_db), int'(e.db));
                        cur_w = e.w;
                    end else begin
                        cur_w = 0;
                    end
                    held  = bus;
                    mcnt  = 1;
                    phase = 1;
                end
                1: if (lcd_e) begin
                    mcnt++;
                    if (bus != held) check("pulse_bus_stable", int'(bus), int'(held));
                end else begin
                    check("e_width", mcnt, E);
                    check("hold_bus", int'(bus), int'(held));
                    mcnt  = 1;
                    phase = 2;
                end
                default: if (wr_ready || lcd_e || (bus != held)) begin
                    check("hold_wait_len", mcnt, 1 + cur_w);
                    phase = 0;
                end else begin
                    mcnt++;
                end
            endcase
        end
        prev_bus = bus;
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_lcd_e"}, int'(lcd_e), 0);
        check({tag, "_lcd_db"}, int'(lcd_db), 0);
        check({tag, "_lcd_rs"}, int'(lcd_rs), 0);
        check({tag, "_lcd_rw"}, int'(lcd_rw), 0);
        check({tag, "_wr_ready"}, int'(wr_ready), 0);
        check({tag, "_cfg_done"}, int'(cfg_done), 0);
    endtask

    task automatic do_init();
        int k;
        bit early;
        expect_tx(1'b0, 8'h38, WC);
        expect_tx(1'b0, 8'h06, WC);
        expect_tx(1'b0, 8'h0C, WC);
        expect_tx(1'b0, 8'h01, WCL);
        init_done = 1'b1;
        @(posedge clk); #1;
        init_done = 1'b0;
        k = 0;
        early = 0;
        while (!wr_ready && k < INIT_COST + 100) begin
            if (cfg_done) early = 1;
            @(posedge clk); #1;
            k++;
        end
        check("init_latency", k, INIT_COST);
        check("cfg_done_early", int'(early), 0);
        check("cfg_done_at_ready", int'(cfg_done), 1);
    endtask

    // Handshake one byte; lat > 0 measures cycles from acceptance to wr_ready.
    task automatic send(input logic rs, input logic [7:0] d, input int lat,
                        input bit hold_valid, input bit pulse_init);
        int k;
        wr_rs    = rs;
        wr_data  = d;
        wr_valid = 1'b1;
        k = 0;
        while (!wr_ready && k < 2000) begin
            @(posedge clk); #1;
            k++;
        end
        if (!wr_ready) check("ready_timeout", int'(wr_ready), 1);
        init_done = pulse_init;
        @(posedge clk); #1;
        init_done = 1'b0;
        if (!hold_valid) wr_valid = 1'b0;
        if (lat > 0) begin
            k = 0;
            while (!wr_ready && k < lat + 100) begin
                @(posedge clk); #1;
                k++;
            end
            check("ready_latency", k, lat);
        end
    endtask

    initial begin
        int k;
        bit seen;

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;

        do_init();

        expect_tx(1'b1, 8'h41, WC);  send(1'b1, 8'h41, N_COST, 0, 0);
        expect_tx(1'b0, 8'h01, WCL); send(1'b0, 8'h01, C_COST, 0, 0);
        expect_tx(1'b0, 8'h02, WCL); send(1'b0, 8'h02, C_COST, 0, 0);
        expect_tx(1'b0, 8'h80, WC);  send(1'b0, 8'h80, N_COST, 0, 0);

        // Back-to-back with valid held; init_done raised on one acceptance edge.
        expect_tx(1'b1, 8'h42, WC);  send(1'b1, 8'h42, N_COST, 1, 0);
        expect_tx(1'b1, 8'h43, WC);  send(1'b1, 8'h43, N_COST, 1, 1);
        expect_tx(1'b1, 8'h44, WC);  send(1'b1, 8'h44, N_COST, 0, 0);
        check("cfg_done_stays", int'(cfg_done), 1);

        // Reset in the middle of the enable pulse.
        expect_tx(1'b1, 8'h55, WC);
        send(1'b1, 8'h55, 0, 0, 0);
        k = 0;
        while (!lcd_e && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        check("pulse_reached", int'(lcd_e), 1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check_all_zero("midreset");
        reset = 1'b0;
        seen = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (lcd_e || wr_ready || cfg_done || (lcd_db != 8'h00)) seen = 1;
        end
        check("idle_after_reset", int'(seen), 0);

        do_init();
        expect_tx(1'b1, 8'h5A, WC);  send(1'b1, 8'h5A, N_COST, 0, 0);

`ifdef LCD_AUTO_WRAP_EN
        begin
            int lat;
            expect_tx(1'b0, 8'h01, WCL); send(1'b0, 8'h01, C_COST, 0, 0);
            for (int i = 0; i < 33; i++) begin
                lat = N_COST;
                if (i == 16) begin expect_tx(1'b0, 8'hC0, WC); lat = 2 * N_COST; end
                if (i == 32) begin expect_tx(1'b0, 8'h80, WC); lat = 2 * N_COST; end
                expect_tx(1'b1, 8'(8'h30 + i), WC);
                send(1'b1, 8'(8'h30 + i), lat, 0, 0);
            end
            expect_tx(1'b0, 8'h01, WCL); send(1'b0, 8'h01, C_COST, 0, 0);
            for (int i = 0; i < 17; i++) begin
                lat = N_COST;
                if (i == 16) begin expect_tx(1'b0, 8'hC0, WC); lat = 2 * N_COST; end
                expect_tx(1'b1, 8'(8'h61 + i), WC);
                send(1'b1, 8'(8'h61 + i), lat, 0, 0);
            end
        end
`endif

        repeat (5) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_writer.md
Name: lcd_writer

Overview:
- Downstream stage of the LCD power-on init sequencer; starts when the sequencer pulses done.
- Issues the HD44780 configuration commands, then accepts command/character bytes from the application over a valid/ready handshake.
- Generates lcd_rs, lcd_e and lcd_db with the required setup, pulse-width and execution delays.
- Its bus outputs are zero whenever it is not writing, so the top level ORs them with the init sequencer's bus.

Parameters:
- E_CYCLES, 12, lcd_e high time in clk cycles (240 ns at 50 MHz).
- WAIT_CMD, 2000, post-write execution wait for normal commands and data (40 us).
- WAIT_CLEAR, 82000, post-write wait for clear (0x01) and home (0x02) commands (1.64 ms).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- init_done  in  1  one-cycle pulse from the init sequencer
- wr_valid  in  1  application byte valid
- wr_rs  in  1  0 = command, 1 = character data
- wr_data  in  8  byte to write
- wr_ready  out  1  block can accept a byte this cycle
- cfg_done  out  1  configuration complete; stays high until reset
- lcd_db  out  8  LCD data bus
- lcd_rs  out  1  LCD register select
- lcd_rw  out  1  tied 0 (write-only)
- lcd_e  out  1  LCD enable strobe

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- Reset values: state IDLE; lcd_e=0, lcd_rs=0, lcd_db=0, wr_ready=0, cfg_done=0. lcd_rw is always 0.
- Reset mid-transaction: aborts the transaction; all outputs are zero on the next cycle.
- States: IDLE, SETUP, PULSE, HOLD, WAIT, READY.
- IDLE:
  - init_done sampled high → SETUP with the first configuration byte.
  - init_done is ignored in every other state; re-initialisation happens only through reset.
- Configuration ROM (index 0..3): 0x38 (8-bit, 2-line), 0x06 (entry mode), 0x0C (display on), 0x01 (clear). All sent with rs=0.
- Per-byte transaction:
  - SETUP: 1 cycle, db/rs driven, e=0.
  - PULSE: E_CYCLES cycles, e=1.
  - HOLD: 1 cycle, e=0, db/rs held.
  - WAIT: WAIT_CLEAR cycles if rs=0 and byte is 0x01 or 0x02; otherwise WAIT_CMD cycles. db/rs held.
  - Outputs drop to 0 on leaving WAIT.
- After WAIT:
  - Next ROM entry, if configuration is unfinished.
  - Otherwise READY, with cfg_done set on entry.
  - After an application byte, return to READY.
- Transaction cost: 1 + E_CYCLES + 1 + wait = 2014 cycles (normal) or 82014 cycles (clear/home) at defaults.
- Handshake:
  - wr_ready=1 only in READY.
  - Transfer occurs when wr_valid && wr_ready at a clk edge; wr_rs and wr_data are captured on that edge; next state is SETUP.
  - wr_ready is 0 from the following cycle until READY is re-entered.
  - wr_valid outside READY is held off without loss; the source must keep its data stable.
- Timer: down-counter loaded on each state entry; its zero flag advances the state. No count wraps, because the maximum load (82000) fits in 17 bits.

Optional Feature:
- Macro: LCD_AUTO_WRAP_EN.
- Enabled:
  - A 5-bit column counter (0..31) increments on each accepted data byte (rs=1).
  - Before a data byte at column 16, the block inserts command 0xC0 (line 2). Before a data byte at column 32, it inserts 0x80 and the counter restarts at 0.
  - The inserted command is a full normal transaction preceding the character; wr_ready stays 0 throughout.
  - An accepted command 0x01/0x02 resets the column to 0. An accepted rs=0 byte with bit 7 set loads the column from bits 6 and 3:0, as line*16 + (addr & 0xF).
- Disabled: no counter; bytes pass straight through.

Decomposition:
- Package lcd_pkg:
  - state encoding;
  - command constants CMD_FUNC_SET=0x38, CMD_ENTRY=0x06, CMD_DISP_ON=0x0C, CMD_CLEAR=0x01, CMD_HOME=0x02, CMD_LINE1=0x80, CMD_LINE2=0xC0;
  - default timing constants, shared with the init sequencer.
- Sub-module lcd_timer: load-able 17-bit down-counter with a zero flag.

Test Plan:
- Reset, then an init_done pulse → lcd_db shows 0x38, 0x06, 0x0C, 0x01 in order. Each lcd_e pulse is 12 cycles wide. cfg_done and wr_ready rise exactly 88056 cycles after the edge that sampled init_done.
- Data write rs=1, 0x41 in READY → lcd_rs=1 and db=0x41 one cycle before e rises. e is high 12 cycles. wr_ready returns 2014 cycles after acceptance.
- Command 0x01 accepted → wr_ready stays low 82014 cycles. Command 0x02 gives the same. Command 0x80 gives 2014 cycles.
- wr_valid held high for 3 bytes back-to-back → exactly 3 transactions in order, no byte dropped or duplicated. init_done pulsed mid-stream has no effect.
- Reset asserted during PULSE → lcd_e=0, lcd_db=0, wr_ready=0, cfg_done=0 on the next cycle. Afterwards the block waits for a new init_done.
- With LCD_AUTO_WRAP_EN: 17 data bytes → a 0xC0 rs=0 transaction precedes the 17th byte. After 33 bytes, a 0x80 precedes the 33rd byte. A clear resets the column.
